// File: rtl/video_pkg.sv
// Shared video types: per-pixel RGB colour and the sync/enable side channel.
package video_pkg;

  localparam int COLOUR_BITS = 8;

  typedef struct packed {
    logic [COLOUR_BITS-1:0] r;
    logic [COLOUR_BITS-1:0] g;
    logic [COLOUR_BITS-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register for aligning side channels with a pipelined datapath.
// DEPTH=0 is a pure wire.
module sync_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctl;
      assign unused_ctl = i_clk ^ i_rst;
      assign o_data     = i_data;
    end else begin : g_line
      logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

      always_comb begin
        stage_d    = stage_q;
        stage_d[0] = i_data;
        for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) stage_q <= '0;
        else       stage_q <= stage_d;
      end

      assign o_data = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/text_layer_compositor.sv
// Merges prioritised one-bit text overlay layers into a single RGB pixel over a
// background, with frame-counted blink, and re-aligns hsync/vsync/de with the colour.
module text_layer_compositor
  import video_pkg::sync_t;
#(
  parameter int NUM_LAYERS   = 3,
  parameter int COLOUR_BITS  = 8,
  parameter int SYNC_DELAY   = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_hsync,
  input  logic                              i_vsync,
  input  logic                              i_de,
  input  logic                              i_nf,
  input  logic [NUM_LAYERS-1:0]             i_layer_dv,
  input  logic [NUM_LAYERS-1:0]             i_layer_data,
  input  logic [NUM_LAYERS*3*COLOUR_BITS-1:0] i_layer_fg,
  input  logic [3*COLOUR_BITS-1:0]          i_bg_colour,
  input  logic [NUM_LAYERS-1:0]             i_blink_mask,
  output logic [COLOUR_BITS-1:0]            o_r,
  output logic [COLOUR_BITS-1:0]            o_g,
  output logic [COLOUR_BITS-1:0]            o_b,
  output logic                              o_hsync,
  output logic                              o_vsync,
  output logic                              o_de
);

  localparam int PW = 3 * COLOUR_BITS;
  localparam int CW = $clog2(BLINK_FRAMES + 1);
  localparam logic [0:0] ST_VISIBLE = 1'b0;
  localparam logic [0:0] ST_HIDDEN  = 1'b1;

  // Sync path: delay line matches overlay read latency, output register matches composite.
  sync_t              sync_in, sync_dly, sync_q, sync_d;
  logic [$bits(sync_t)-1:0] sync_dly_bits;

  assign sync_in = '{hsync: i_hsync, vsync: i_vsync, de: i_de};

  sync_delay_line #(
    .WIDTH($bits(sync_t)),
    .DEPTH(SYNC_DELAY)
  ) u_sync_dly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_data(sync_in),
    .o_data(sync_dly_bits)
  );

  assign sync_dly = sync_dly_bits;
  assign sync_d   = sync_dly;

  // Blink FSM; the new phase is used in the same cycle as i_nf.
  logic [CW-1:0] cnt_q, cnt_d;
  logic [0:0]    phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (i_nf) begin
      if (cnt_q == CW'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = (phase_q == ST_VISIBLE) ? ST_HIDDEN : ST_VISIBLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  logic [NUM_LAYERS-1:0] opaque;
  assign opaque = i_layer_dv & i_layer_data
                & ~(i_blink_mask & {NUM_LAYERS{phase_d == ST_HIDDEN}});

  // Lowest opaque index wins; iterating downward lets it overwrite higher ones.
  logic [PW-1:0] colour_q, colour_d;

  always_comb begin
    colour_d = i_bg_colour;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (opaque[i]) colour_d = i_layer_fg[i*PW +: PW];
    end
    if (!sync_dly.de) colour_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q    <= '0;
      phase_q  <= ST_VISIBLE;
      colour_q <= '0;
      sync_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      colour_q <= colour_d;
      sync_q   <= sync_d;
    end
  end

  assign o_r     = colour_q[PW-1 -: COLOUR_BITS];
  assign o_g     = colour_q[2*COLOUR_BITS-1 -: COLOUR_BITS];
  assign o_b     = colour_q[COLOUR_BITS-1:0];
  assign o_hsync = sync_q.hsync;
  assign o_vsync = sync_q.vsync;
  assign o_de    = sync_q.de;

endmodule

// File: tb/tb_text_layer_compositor.sv
// Scoreboard bench: two builds (SYNC_DELAY 4 and 0) share stimulus; expected pixels are
// queued at issue time and a negedge monitor pops and compares.
module tb_text_layer_compositor;

  localparam int NL = 3;
  localparam int CB = 8;
  localparam int BF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, hs, vs, de, nf;
  logic [NL-1:0]      dv, dat, bmask;
  logic [NL*3*CB-1:0] fg;
  logic [3*CB-1:0]    bg;

  logic [CB-1:0] r4, g4, b4, r0, g0, b0;
  logic          h4, v4, de4, h0, v0, de0;

  text_layer_compositor #(.NUM_LAYERS(NL), .COLOUR_BITS(CB), .SYNC_DELAY(4), .BLINK_FRAMES(BF)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_hsync(hs), .i_vsync(vs), .i_de(de), .i_nf(nf),
    .i_layer_dv(dv), .i_layer_data(dat), .i_layer_fg(fg), .i_bg_colour(bg), .i_blink_mask(bmask),
    .o_r(r4), .o_g(g4), .o_b(b4), .o_hsync(h4), .o_vsync(v4), .o_de(de4));

  text_layer_compositor #(.NUM_LAYERS(NL), .COLOUR_BITS(CB), .SYNC_DELAY(0), .BLINK_FRAMES(BF)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_hsync(hs), .i_vsync(vs), .i_de(de), .i_nf(nf),
    .i_layer_dv(dv), .i_layer_data(dat), .i_layer_fg(fg), .i_bg_colour(bg), .i_blink_mask(bmask),
    .o_r(r0), .o_g(g0), .o_b(b0), .o_hsync(h0), .o_vsync(v0), .o_de(de0));

  typedef struct {
    logic [3*CB+2:0] val;
    string           tag;
  } exp_t;

  exp_t       q4[$], q0[$];
  exp_t       m4, m0;
  int         checks = 0;
  int         errors = 0;
  logic [2:0] hist[4];
  int         nf_cnt = 0;
  string      tag = "init";
  bit         done = 1'b0;

  // Reference colour: scan from layer 0 and return the first visible glyph pixel.
  function automatic logic [3*CB-1:0] pick(bit hidden);
    for (int i = 0; i < NL; i++) begin
      if (dv[i] && dat[i] && !(bmask[i] && hidden)) return fg[i*3*CB +: 3*CB];
    end
    return bg;
  endfunction

  task automatic cyc();
    exp_t            e4, e0;
    logic [2:0]      s, d4;
    logic [3*CB-1:0] col;
    int              nfc;
    bit              hid;
    s = {hs, vs, de};
    if (rst) begin
      e4.val = '0;
      e0.val = '0;
      for (int k = 0; k < 4; k++) hist[k] = '0;
      nf_cnt = 0;
    end else begin
      nfc    = nf_cnt + int'(nf);
      hid    = ((nfc / BF) % 2) == 1;
      col    = pick(hid);
      d4     = hist[3];
      e4.val = {(d4[0] ? col : {3*CB{1'b0}}), d4};
      e0.val = {(s[0] ? col : {3*CB{1'b0}}), s};
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = s;
      nf_cnt  = nfc;
    end
    e4.tag = tag;
    e0.tag = tag;
    q4.push_back(e4);
    q0.push_back(e0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q4.size() >= 2 || (done && q4.size() > 0)) begin
      m4 = q4.pop_front();
      checks++;
      if ({r4, g4, b4, h4, v4, de4} !== m4.val) begin
        errors++;
        $display("FAIL %s sd4 got rgb/hvd=%h required %h", m4.tag, {r4, g4, b4, h4, v4, de4}, m4.val);
      end
    end
    if (q0.size() >= 2 || (done && q0.size() > 0)) begin
      m0 = q0.pop_front();
      checks++;
      if ({r0, g0, b0, h0, v0, de0} !== m0.val) begin
        errors++;
        $display("FAIL %s sd0 got rgb/hvd=%h required %h", m0.tag, {r0, g0, b0, h0, v0, de0}, m0.val);
      end
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) hist[k] = '0;
    rst = 1'b1; hs = 1'b1; vs = 1'b0; de = 1'b1; nf = 1'b0;
    dv = '0; dat = '0; bmask = '0;
    fg = {24'h0000FF, 24'hABCDEF, 24'hFF0000};
    bg = 24'h101010;

    // Reset held with an i_nf to show reset wins, then line fill after release.
    tag = "reset";
    repeat (4) cyc();
    nf = 1'b1; cyc(); nf = 1'b0;
    rst = 1'b0;
    tag = "fill";
    repeat (8) cyc();

    // Single-cycle de pulse with layer 0 arriving SYNC_DELAY cycles later.
    tag = "pulse";
    de = 1'b0; hs = 1'b0;
    repeat (6) cyc();
    de = 1'b1; cyc(); de = 1'b0;
    repeat (3) cyc();
    dv = 3'b001; dat = 3'b001; cyc();
    dv = 3'b000; dat = 3'b000;
    repeat (4) cyc();

    // Priority, dv gating and mid-line colour changes.
    tag = "prio";
    de = 1'b1; hs = 1'b1; vs = 1'b1;
    fg = {24'h0000FF, 24'hABCDEF, 24'h00FF00};
    repeat (5) cyc();
    dv = 3'b101; dat = 3'b101; repeat (2) cyc();
    tag = "drop0";
    dv = 3'b100; dat = 3'b101; repeat (2) cyc();
    tag = "transp";
    dv = 3'b000; dat = 3'b000; vs = 1'b0; repeat (2) cyc();
    tag = "dvgate";
    dv = 3'b000; dat = 3'b010; repeat (2) cyc();
    tag = "layer1";
    dv = 3'b010; dat = 3'b010; cyc();
    dv = 3'b011; dat = 3'b010; cyc();
    dv = 3'b111; dat = 3'b000; cyc();
    tag = "bgchg";
    bg = 24'h202020; cyc();
    bg = 24'h101010; cyc();
    fg[23:0] = 24'h123456; dv = 3'b001; dat = 3'b001; cyc();
    dv = 3'b000; dat = 3'b000; de = 1'b0; hs = 1'b0; repeat (2) cyc();

    // Blink: layer 0 masked, frames 0-1 visible, 2-3 hidden, 4 visible.
    tag = "blink";
    fg = {24'h0000FF, 24'hABCDEF, 24'hFF0000};
    de = 1'b1; hs = 1'b1; bmask = 3'b001; dv = 3'b001; dat = 3'b001;
    repeat (6) cyc();
    for (int f = 1; f <= 4; f++) begin
      nf = 1'b1; cyc(); nf = 1'b0;
      repeat (5) cyc();
    end

    // Reach frame 3 (hidden), reset mid-frame, then visible again after release.
    tag = "blinkrst";
    for (int f = 1; f <= 3; f++) begin
      nf = 1'b1; cyc(); nf = 1'b0;
      repeat (5) cyc();
    end
    dv = 3'b101; dat = 3'b101;
    cyc();
    rst = 1'b1; repeat (2) cyc();
    rst = 1'b0;
    repeat (7) cyc();
    for (int f = 1; f <= 2; f++) begin
      nf = 1'b1; cyc(); nf = 1'b0;
      repeat (6) cyc();
    end

    done = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (q4.size() != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL drain left q4=%0d q0=%0d required 0", q4.size(), q0.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
